// File: rtl/pulse_stretcher_if.sv
// Trigger/status bundle for pulse_stretcher: the controller drives trigger,
// the stretcher returns the stretched level and its queue status.
interface pulse_stretcher_if #(
  parameter int MAX_PENDING = 3
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          trigger;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          drop;

  modport master (output trigger, input out, busy, pending, drop);
  modport slave  (input trigger, output out, busy, pending, drop);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HOLD_CYC-long highs separated by GAP_CYC lows.
// Define PULSE_STRETCHER_QUEUE_EN to queue (rather than drop) triggers seen while busy.
module pulse_stretcher #(
  parameter int FREQ        = 100_000_000,
  parameter int HOLD_US     = 500,
  parameter int GAP_US      = 100,
  parameter int MAX_PENDING = 3
) (
  input  logic             clk,
  input  logic             rstn,
  pulse_stretcher_if.slave bus
);
  // 64-bit math: FREQ*HOLD_US overflows 32 bits at the default settings
  localparam longint HOLD_CYC_L = longint'(FREQ) * longint'(HOLD_US) / longint'(1_000_000);
  localparam longint GAP_CYC_L  = longint'(FREQ) * longint'(GAP_US)  / longint'(1_000_000);
  localparam int     HOLD_CYC   = int'(HOLD_CYC_L);
  localparam int     GAP_CYC    = int'(GAP_CYC_L);
  localparam int     MAX_CYC    = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int     CW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int     PW         = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
  localparam bit            GAP_ZERO  = (GAP_CYC == 0);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_out, w_out_nxt;
  logic          r_busy;
  logic          r_drop, w_drop_nxt;
  logic [PW-1:0] r_pend, w_pend_nxt;
  logic          w_hold_end, w_gap_end, w_decide, w_queue, w_replay;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_drop  <= w_drop_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_pend_nxt  = r_pend;
    w_drop_nxt  = 1'b0;
    w_hold_end  = (r_state == S_HOLD) && (r_cnt == HOLD_LAST);
    w_gap_end   = (r_state == S_GAP)  && (r_cnt == GAP_LAST);
    // With no gap, the end of HOLD is itself the replay decision point
    w_decide    = w_gap_end || (w_hold_end && GAP_ZERO);
    w_queue     = bus.trigger && (r_state != S_IDLE);
`ifdef PULSE_STRETCHER_QUEUE_EN
    // A trigger arriving on the decision cycle is replayed directly
    w_replay = w_decide && ((r_pend != '0) || w_queue);
    if (w_queue && !w_replay) begin
      if (r_pend == PW'(MAX_PENDING)) w_drop_nxt = 1'b1;
      else                            w_pend_nxt = r_pend + 1'b1;
    end else if (!w_queue && w_replay) begin
      w_pend_nxt = r_pend - 1'b1;
    end
`else
    w_replay   = 1'b0;
    w_drop_nxt = w_queue;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.trigger) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b1;
        end
      end
      S_HOLD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_hold_end) begin
          w_cnt_nxt   = '0;
          w_out_nxt   = w_replay;
          w_state_nxt = w_replay ? S_HOLD : (GAP_ZERO ? S_IDLE : S_GAP);
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_gap_end) begin
          w_cnt_nxt   = '0;
          w_out_nxt   = w_replay;
          w_state_nxt = w_replay ? S_HOLD : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.out     = r_out;
  assign bus.busy    = r_busy;
  assign bus.pending = r_pend;
  assign bus.drop    = r_drop;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: HOLD_CYC=5 / GAP_CYC=2 on dut A, GAP_CYC=0 on dut B.
// Per-cycle expectations are queued as stimulus is driven and popped after each edge.
module tb_pulse_stretcher;
  localparam int T = 0, O = 1, B = 2, D = 3, P = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pulse_stretcher_if #(.MAX_PENDING(3)) bus_a ();
  pulse_stretcher_if #(.MAX_PENDING(3)) bus_b ();

  pulse_stretcher #(.FREQ(1_000_000), .HOLD_US(5), .GAP_US(2), .MAX_PENDING(3)) u_dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a.slave));
  pulse_stretcher #(.FREQ(1_000_000), .HOLD_US(5), .GAP_US(0), .MAX_PENDING(3)) u_dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b.slave));

  typedef struct packed {
    logic       out;
    logic       busy;
    logic [1:0] pend;
    logic       drop;
  } exp_t;

  exp_t sb[$];
  bit   tr[64];
  bit   eo[64];
  bit   eb[64];
  bit   ed[64];
  int   ep[64];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int cyc, input logic [3:0] got, input logic [3:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 64; i++) begin
      tr[i] = 1'b0; eo[i] = 1'b0; eb[i] = 1'b0; ed[i] = 1'b0; ep[i] = 0;
    end
  endtask

  task automatic setr(input int w, input int a, input int b, input int v);
    for (int i = a; i < b; i++) begin
      case (w)
        T: tr[i] = v[0];
        O: eo[i] = v[0];
        B: eb[i] = v[0];
        D: ed[i] = v[0];
        default: ep[i] = v;
      endcase
    end
  endtask

  task automatic chk_zero(input bit sel_b, input string tag);
    if (sel_b) begin
      chk({tag, "_out"},  -1, {3'b0, bus_b.out},  4'd0);
      chk({tag, "_busy"}, -1, {3'b0, bus_b.busy}, 4'd0);
      chk({tag, "_pend"}, -1, {2'b0, bus_b.pending}, 4'd0);
      chk({tag, "_drop"}, -1, {3'b0, bus_b.drop}, 4'd0);
    end else begin
      chk({tag, "_out"},  -1, {3'b0, bus_a.out},  4'd0);
      chk({tag, "_busy"}, -1, {3'b0, bus_a.busy}, 4'd0);
      chk({tag, "_pend"}, -1, {2'b0, bus_a.pending}, 4'd0);
      chk({tag, "_drop"}, -1, {3'b0, bus_a.drop}, 4'd0);
    end
  endtask

  // Cycle i: trigger tr[i] is sampled by edge i; expectations describe the state after edge i
  task automatic run(input bit sel_b, input int n, input string tag);
    exp_t e;
    logic o, bz, dr;
    logic [1:0] pd;
    for (int i = 0; i < n; i++) begin
      if (sel_b) bus_b.trigger = tr[i];
      else       bus_a.trigger = tr[i];
      sb.push_back('{out: eo[i], busy: eb[i], pend: 2'(ep[i]), drop: ed[i]});
      @(posedge clk);
      #1;
      e  = sb.pop_front();
      o  = sel_b ? bus_b.out     : bus_a.out;
      bz = sel_b ? bus_b.busy    : bus_a.busy;
      pd = sel_b ? bus_b.pending : bus_a.pending;
      dr = sel_b ? bus_b.drop    : bus_a.drop;
      chk({tag, "_out"},  i, {3'b0, o},  {3'b0, e.out});
      chk({tag, "_busy"}, i, {3'b0, bz}, {3'b0, e.busy});
      chk({tag, "_pend"}, i, {2'b0, pd}, {2'b0, e.pend});
      chk({tag, "_drop"}, i, {3'b0, dr}, {3'b0, e.drop});
    end
    bus_a.trigger = 1'b0;
    bus_b.trigger = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    bus_a.trigger = 1'b0;
    bus_b.trigger = 1'b0;
    #1 rstn = 1'b0;
    #2;
    chk_zero(1'b0, "rst_a");
    chk_zero(1'b1, "rst_b");
    #9 rstn = 1'b1;

    // Single trigger: 5 high, busy 7
    clr();
    setr(T, 0, 1, 1); setr(O, 0, 5, 1); setr(B, 0, 7, 1);
    run(1'b0, 10, "single");

    // Triggers at 0, 2, 6
    clr();
    setr(T, 0, 1, 1); setr(T, 2, 3, 1); setr(T, 6, 7, 1);
`ifdef PULSE_STRETCHER_QUEUE_EN
    setr(O, 0, 5, 1); setr(O, 7, 12, 1); setr(O, 14, 19, 1); setr(B, 0, 21, 1);
    setr(P, 2, 6, 1); setr(P, 6, 7, 2); setr(P, 7, 14, 1);
`else
    setr(O, 0, 5, 1); setr(B, 0, 7, 1); setr(D, 2, 3, 1); setr(D, 6, 7, 1);
`endif
    run(1'b0, 24, "three");

    // Trigger held for 6 cycles
    clr();
    setr(T, 0, 6, 1);
`ifdef PULSE_STRETCHER_QUEUE_EN
    setr(O, 0, 5, 1); setr(O, 7, 12, 1); setr(O, 14, 19, 1); setr(O, 21, 26, 1);
    setr(B, 0, 28, 1);
    setr(P, 1, 2, 1); setr(P, 2, 3, 2); setr(P, 3, 7, 3); setr(P, 7, 14, 2); setr(P, 14, 21, 1);
    setr(D, 4, 6, 1);
`else
    setr(O, 0, 5, 1); setr(B, 0, 7, 1); setr(D, 1, 6, 1);
`endif
    run(1'b0, 32, "held");

    // Build up pending mid-HOLD, then asynchronous reset between edges
    clr();
    setr(T, 0, 3, 1); setr(O, 0, 3, 1); setr(B, 0, 3, 1);
`ifdef PULSE_STRETCHER_QUEUE_EN
    setr(P, 1, 2, 1); setr(P, 2, 3, 2);
`else
    setr(D, 1, 3, 1);
`endif
    run(1'b0, 3, "prerst");
    #2 rstn = 1'b0;
    #1 chk_zero(1'b0, "asyncrst");
    #2 rstn = 1'b1;

    clr();
    setr(T, 0, 1, 1); setr(O, 0, 5, 1); setr(B, 0, 7, 1);
    run(1'b0, 10, "fresh");

    // Zero gap: two triggers one cycle apart
    clr();
    setr(T, 0, 2, 1);
`ifdef PULSE_STRETCHER_QUEUE_EN
    setr(O, 0, 10, 1); setr(B, 0, 10, 1); setr(P, 1, 5, 1);
`else
    setr(O, 0, 5, 1); setr(B, 0, 5, 1); setr(D, 1, 2, 1);
`endif
    run(1'b1, 14, "gap0");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
